uart_port_select: RTL



---
 rtl/uart_port_select.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_port_select.sv
// Selects one of NUM_PORTS physical UART pin pairs for the single SoC UART.
// Locks onto the first port with a filtered start bit and releases it after an idle timeout.
module uart_port_select #(
  parameter int NUM_PORTS     = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 65536,
  parameter int MIRROR_TX     = 1,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] rx_i,
  output logic [NUM_PORTS-1:0] tx_o,
  output logic                 soc_rx_o,
  input  logic                 soc_tx_i,
  output logic [PW-1:0]        active_port_o,
  output logic                 locked_o
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT);

  typedef enum logic {SCAN, LOCKED} state_t;

  logic [NUM_PORTS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PORTS-1:0] sync_d [SYNC_STAGES];
  logic [NUM_PORTS-1:0] rx_s;

  state_t               state_q, state_d;
  logic [PW-1:0]        cand_q, cand_d;
  logic [PW-1:0]        active_q, active_d;
  logic [GW-1:0]        glitch_cnt_q, glitch_cnt_d;
  logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                 soc_rx_q, soc_rx_d;
  logic [NUM_PORTS-1:0] tx_q, tx_d;

  logic [PW-1:0]        cand;
  logic                 any_low;
  logic [GW-1:0]        glitch_eff;

  always_comb begin
    sync_d[0] = rx_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign any_low = ~&rx_s;

  // Scan from the top so the lowest low port is the final assignment.
  always_comb begin
    cand = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (!rx_s[i]) cand = PW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    active_d     = active_q;
    glitch_cnt_d = glitch_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    glitch_eff   = '0;
    soc_rx_d     = 1'b1;
    tx_d         = '1;

    case (state_q)
      SCAN: begin
        soc_rx_d = &rx_s;
        if (!any_low) begin
          glitch_cnt_d = '0;
        end else begin
          cand_d = cand;
          // A new candidate starts its filter from zero rather than inheriting the count.
          glitch_eff = (cand == cand_q) ? glitch_cnt_q : '0;
          if (glitch_eff == GW'(GLITCH_CYCLES - 1)) begin
            state_d      = LOCKED;
            active_d     = cand;
            idle_cnt_d   = '0;
            glitch_cnt_d = '0;
          end else begin
            glitch_cnt_d = glitch_eff + GW'(1);
          end
        end
      end
      LOCKED: begin
        soc_rx_d = rx_s[active_q];
        if (!rx_s[active_q] || !soc_tx_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
          state_d = SCAN;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      default: state_d = SCAN;
    endcase

    if (MIRROR_TX != 0) begin
      tx_d = {NUM_PORTS{soc_tx_i}};
    end else if (state_q == LOCKED) begin
      tx_d[active_q] = soc_tx_i;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '1;
      end
      state_q      <= SCAN;
      cand_q       <= '0;
      active_q     <= '0;
      glitch_cnt_q <= '0;
      idle_cnt_q   <= '0;
      soc_rx_q     <= 1'b1;
      tx_q         <= '1;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      state_q      <= state_d;
      cand_q       <= cand_d;
      active_q     <= active_d;
      glitch_cnt_q <= glitch_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      soc_rx_q     <= soc_rx_d;
      tx_q         <= tx_d;
    end
  end

  assign tx_o          = tx_q;
  assign soc_rx_o      = soc_rx_q;
  assign active_port_o = active_q;
  assign locked_o      = (state_q == LOCKED);

endmodule
